shift_add_multiplier: RTL and testbench
=======================================

// Module: shift_add_multiplier
// PURPOSE
//   Parametrised sequential multiplier: radix-2 shift-and-add, one partial product per cycle,
//   start/busy/done handshake. Successor to the fixed 16-bit repeated-addition multiplier:
//   - width is parametric
//   - signed mode
//   - optional early exit
//   - synchronous reset
//   Used as the arithmetic engine behind bus-loaded operand registers.
// PARAMETERS
//   WIDTH       16  operand width in bits (>=2); product is 2*WIDTH bits
//   SIGNED      0   1: operands and product are two's complement; 0: unsigned
//   EARLY_EXIT  0   1: CALC ends as soon as the remaining multiplier bits are all zero
// PORTS
//   clock    in   1        all state updates on the falling edge of clock
//   reset_n  in   1        synchronous, active-low; sampled on the same falling edge
//   start    in   1        request; sampled only in IDLE
//   a        in   WIDTH    multiplicand, captured when start is accepted
//   b        in   WIDTH    multiplier, captured when start is accepted
//   product  out  2*WIDTH  result; held stable from done until the next accepted start
//   busy     out  1        high in CALC and FIX
//   done     out  1        one-cycle pulse when product becomes valid
// BEHAVIOUR
//   Reset (reset_n=0 at any edge, including mid-operation):
//     state=IDLE, product=0, busy=0, done=0; in-flight operation is discarded.
//   States: IDLE -> CALC -> FIX -> IDLE.
//   IDLE:
//     start=1 accepted at edge E0.
//     Captures ma=|a| (zero-extended to 2*WIDTH), mb=|b|, acc=0, cnt=WIDTH.
//     neg = a[MSB]^b[MSB] when SIGNED=1, else 0.
//     Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1); it fits unsigned, no special case.
//   CALC, each edge:
//     if mb[0], acc += ma (2*WIDTH-bit add, cannot overflow).
//     Then ma <<= 1, mb >>= 1, cnt -= 1.
//     -> FIX when cnt reaches 0, or (EARLY_EXIT=1 and the shifted mb == 0).
//   FIX, one edge: product <= neg ? -acc : acc; done <= 1; -> IDLE.
//   done drops at the next edge.
//   Latency, EARLY_EXIT=0: done is high after edge E0+WIDTH+1 and low after E0+WIDTH+2.
//     Result is data-independent.
//   Latency, EARLY_EXIT=1: CALC runs k = max(1, bit position of MSB of |b| + 1) cycles.
//     b=0 gives k=1. done follows after edge E0+k+1.
//   Handshake:
//     start is ignored while busy; no queueing.
//     start held high in the cycle done pulses is not accepted (state is FIX).
//     It is accepted on the following edge in IDLE, so back-to-back operations
//     have one IDLE cycle between them.
//   product is never partially updated: it only changes at FIX or reset.
//   busy=1 exactly in CALC and FIX; done and busy are never high in the same cycle.
//     busy falls on the same edge that raises done.
// STRUCTURE
//   Package mult_pkg:
//     state enum {IDLE, CALC, FIX}
//     cnt width localparam $clog2(WIDTH+1)
//     helper function abs_val()
//   Sub-module mult_datapath (ma/mb/acc registers, adder, shifters, zero detect, final negate),
//     driven by load/step/fix strobes from the FSM in this module.
//   mult_datapath returns mb_zero_next and cnt_zero status to the FSM.
// TESTING (WIDTH=8 unless stated)
//   1 Unsigned 13*11, EARLY_EXIT=0:
//     done pulses 1 cycle, 9 edges after start is accepted; product=143; busy high 9 cycles.
//   2 Unsigned 255*255 -> product=65025 (0xFE01).
//     Unsigned 0*200 -> 0, with full 8-cycle CALC.
//   3 SIGNED=1:
//     -7*6 -> 0xFFD6 (-42)
//     -128*-128 -> 0x4000 (16384)
//     -128*127 -> 0xC080 (-16256)
//     127*-1 -> 0xFF81
//   4 EARLY_EXIT=1:
//     b=3 -> CALC 2 cycles, done at E0+3
//     b=0 -> CALC 1 cycle, product 0
//     b=0x80 -> CALC 8 cycles
//   5 start re-pulsed during CALC with new a/b:
//     ignored; product reflects the original operands.
//     start held high through done: next op accepted one edge after done,
//     and product holds the previous result until that op's FIX.
//   6 reset_n low for 1 edge mid-CALC:
//     product=0, busy=0, done=0 on that edge, no done pulse follows.
//     Next start completes correctly, e.g. 9*9 -> 81.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and helpers for the shift-and-add multiplier
package mult_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    // Widest operand the magnitude helper handles
    localparam int ABS_W = 64;

    // Counter width able to hold the value WIDTH
    function automatic int cnt_bits(input int width);
        return $clog2(width + 1);
    endfunction

    // Two's complement magnitude of a zero-extended operand; callers keep the low WIDTH bits,
    // which makes the most negative value map to 2^(WIDTH-1) without a special case
    function automatic logic [ABS_W-1:0] abs_val(input logic [ABS_W-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// mult_datapath: operand/accumulator registers, shift-add step and final sign fix (WIDTH <= 64)
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SIGNED = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic               step,
    input  logic               fix,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               mb_zero_next,
    output logic               cnt_zero
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_bits(WIDTH);

    logic [PW-1:0]    ma_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    acc_d;
    logic [PW-1:0]    product_q;
    logic [WIDTH-1:0] mb_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q;
    logic             sa;
    logic             sb;

    assign sa           = (SIGNED != 0) && a[WIDTH-1];
    assign sb           = (SIGNED != 0) && b[WIDTH-1];
    assign acc_d        = mb_q[0] ? acc_q + ma_q : acc_q;
    assign mb_zero_next = (mb_q >> 1) == '0;
    assign cnt_zero     = cnt_q == CW'(1);
    assign product      = product_q;

    // Capture magnitudes on load, add-and-shift per step, apply sign once on fix
    always_ff @(negedge clock) begin
        if (!reset_n) begin
            ma_q      <= '0;
            mb_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else if (load) begin
            ma_q  <= PW'(WIDTH'(abs_val(ABS_W'(a), sa)));
            mb_q  <= WIDTH'(abs_val(ABS_W'(b), sb));
            acc_q <= '0;
            cnt_q <= CW'(WIDTH);
            neg_q <= sa ^ sb;
        end else if (step) begin
            acc_q <= acc_d;
            ma_q  <= ma_q << 1;
            mb_q  <= mb_q >> 1;
            cnt_q <= cnt_q - CW'(1);
        end else if (fix) begin
            product_q <= neg_q ? -acc_q : acc_q;
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: radix-2 sequential multiplier with start/busy/done handshake
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int SIGNED     = 0,
    parameter int EARLY_EXIT = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    state_t state_q;
    logic   busy_q;
    logic   done_q;
    logic   load;
    logic   step;
    logic   fix;
    logic   mb_zero_next;
    logic   cnt_zero;
    logic   calc_end;

    assign load     = (state_q == IDLE) && start;
    assign step     = state_q == CALC;
    assign fix      = state_q == FIX;
    assign calc_end = cnt_zero || ((EARLY_EXIT != 0) && mb_zero_next);
    assign busy     = busy_q;
    assign done     = done_q;

    mult_datapath #(
        .WIDTH (WIDTH),
        .SIGNED(SIGNED)
    ) u_datapath (
        .clock       (clock),
        .reset_n     (reset_n),
        .load        (load),
        .step        (step),
        .fix         (fix),
        .a           (a),
        .b           (b),
        .product     (product),
        .mb_zero_next(mb_zero_next),
        .cnt_zero    (cnt_zero)
    );

    // Control FSM; busy falls on the same edge that raises the one-cycle done pulse
    always_ff @(negedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                    end
                end
                CALC: begin
                    if (calc_end) state_q <= FIX;
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: randomized and directed checks over four WIDTH=8 configurations
module tb_shift_add_multiplier;

    localparam int W = 8;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           start_r [4];
    logic [W-1:0]   a_r     [4];
    logic [W-1:0]   b_r     [4];
    logic [2*W-1:0] prod_w  [4];
    logic           busy_w  [4];
    logic           done_w  [4];
    int             checks = 0;
    int             failures = 0;

    always #5 clock = ~clock;

    // Instance g: SIGNED = g%2, EARLY_EXIT = g/2
    for (genvar g = 0; g < 4; g++) begin : g_dut
        shift_add_multiplier #(
            .WIDTH     (W),
            .SIGNED    (g % 2),
            .EARLY_EXIT(g / 2)
        ) dut (
            .clock  (clock),
            .reset_n(reset_n),
            .start  (start_r[g]),
            .a      (a_r[g]),
            .b      (b_r[g]),
            .product(prod_w[g]),
            .busy   (busy_w[g]),
            .done   (done_w[g])
        );
    end

    function automatic int sval(input int c, input logic [W-1:0] v);
        return (c % 2 == 1 && v[W-1]) ? int'(v) - 256 : int'(v);
    endfunction

    function automatic logic [2*W-1:0] exp_prod(input int c, input logic [W-1:0] av, input logic [W-1:0] bv);
        int p;
        p = sval(c, av) * sval(c, bv);
        return p[2*W-1:0];
    endfunction

    function automatic int exp_k(input int c, input logic [W-1:0] bv);
        int mag;
        int k;
        if (c / 2 == 0) return W;
        mag = sval(c, bv);
        if (mag < 0) mag = -mag;
        k = 0;
        while (mag > 0) begin
            k++;
            mag = mag >> 1;
        end
        return (k == 0) ? 1 : k;
    endfunction

    task automatic run_op(input int c, input logic [W-1:0] av, input logic [W-1:0] bv, input int glitch_at, input string name);
        logic [2*W-1:0] ep;
        logic [2*W-1:0] prev;
        int k;
        int dn;
        int bc;
        bit hold_bad;
        ep = exp_prod(c, av, bv);
        k = exp_k(c, bv);
        dn = 0;
        bc = 0;
        hold_bad = 0;
        @(posedge clock);
        prev = prod_w[c];
        a_r[c] = av;
        b_r[c] = bv;
        start_r[c] = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            start_r[c] = 1'b0;
            if (done_w[c]) begin
                dn = n;
                break;
            end
            if (busy_w[c]) bc++;
            if (prod_w[c] !== prev) hold_bad = 1;
            if (glitch_at != 0 && n == glitch_at) begin
                a_r[c] = 8'($urandom);
                b_r[c] = 8'($urandom);
                start_r[c] = 1'b1;
            end
        end
        checks++;
        if (dn != k + 2) begin
            failures++;
            $display("FAIL %s latency cfg%0d %0d*%0d: done at cycle %0d, required %0d", name, c, av, bv, dn, k + 2);
        end
        checks++;
        if (bc != k + 1) begin
            failures++;
            $display("FAIL %s busy_cycles cfg%0d: got %0d, required %0d", name, c, bc, k + 1);
        end
        checks++;
        if (busy_w[c] !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_with_done cfg%0d: busy=%b, required 0", name, c, busy_w[c]);
        end
        checks++;
        if (hold_bad) begin
            failures++;
            $display("FAIL %s product_hold cfg%0d: product changed before done, required %h", name, c, prev);
        end
        checks++;
        if (prod_w[c] !== ep) begin
            failures++;
            $display("FAIL %s product cfg%0d %h*%h: got %h, required %h", name, c, av, bv, prod_w[c], ep);
        end
        @(posedge clock);
        checks++;
        if (done_w[c] !== 1'b0 || prod_w[c] !== ep) begin
            failures++;
            $display("FAIL %s after_done cfg%0d: done=%b product=%h, required done=0 product=%h", name, c, done_w[c], prod_w[c], ep);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (prod_w[c] !== '0 || busy_w[c] !== 1'b0 || done_w[c] !== 1'b0) begin
                failures++;
                $display("FAIL reset cfg%0d: product=%h busy=%b done=%b, required 0/0/0", c, prod_w[c], busy_w[c], done_w[c]);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_unsigned;
        run_op(0, 8'd13, 8'd11, 0, "u_13x11");
        run_op(0, 8'd255, 8'd255, 0, "u_255x255");
        run_op(0, 8'd0, 8'd200, 0, "u_0x200");
    endtask

    task automatic test_signed;
        run_op(1, 8'hF9, 8'd6, 0, "s_m7x6");
        run_op(1, 8'h80, 8'h80, 0, "s_m128xm128");
        run_op(1, 8'h80, 8'h7F, 0, "s_m128x127");
        run_op(1, 8'h7F, 8'hFF, 0, "s_127xm1");
    endtask

    task automatic test_early_exit;
        run_op(2, 8'd77, 8'd3, 0, "ee_b3");
        run_op(2, 8'd77, 8'd0, 0, "ee_b0");
        run_op(2, 8'd77, 8'h80, 0, "ee_b80");
        run_op(3, 8'hF0, 8'hFE, 0, "ee_s_m16xm2");
        run_op(3, 8'h05, 8'h80, 0, "ee_s_5xm128");
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            run_op(int'($urandom_range(0, 3)), 8'($urandom), 8'($urandom) >> $urandom_range(0, 7), 0, "random");
        end
    endtask

    task automatic test_restart_ignored;
        run_op(0, 8'd13, 8'd11, 3, "restart_ignored");
        run_op(3, 8'd100, 8'd6, 2, "restart_ignored_ee");
    endtask

    task automatic test_back_to_back;
        logic [2*W-1:0] old;
        int dn;
        bit hold_bad;
        dn = 0;
        hold_bad = 0;
        @(posedge clock);
        a_r[0] = 8'd5;
        b_r[0] = 8'd7;
        start_r[0] = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            if (done_w[0]) begin
                dn = n;
                break;
            end
        end
        checks++;
        if (dn != 10 || prod_w[0] !== 16'd35) begin
            failures++;
            $display("FAIL b2b_first: done at %0d product=%h, required 10 and %h", dn, prod_w[0], 16'd35);
        end
        old = prod_w[0];
        a_r[0] = 8'd200;
        b_r[0] = 8'd100;
        @(posedge clock);
        start_r[0] = 1'b0;
        checks++;
        if (busy_w[0] !== 1'b1 || done_w[0] !== 1'b0 || prod_w[0] !== 16'd35) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b done=%b product=%h, required 1/0/%h", busy_w[0], done_w[0], prod_w[0], 16'd35);
        end
        dn = 0;
        for (int n = 2; n <= 40; n++) begin
            @(posedge clock);
            if (done_w[0]) begin
                dn = n;
                break;
            end
            if (prod_w[0] !== old) hold_bad = 1;
        end
        checks++;
        if (hold_bad || dn != 10 || prod_w[0] !== 16'd20000) begin
            failures++;
            $display("FAIL b2b_second: hold_bad=%b done at %0d product=%h, required 0, 10, %h", hold_bad, dn, prod_w[0], 16'd20000);
        end
        @(posedge clock);
    endtask

    task automatic test_reset_mid;
        bit stray;
        stray = 0;
        @(posedge clock);
        a_r[0] = 8'd13;
        b_r[0] = 8'd11;
        start_r[0] = 1'b1;
        @(posedge clock);
        start_r[0] = 1'b0;
        repeat (2) @(posedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        checks++;
        if (prod_w[0] !== '0 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: product=%h busy=%b done=%b, required 0/0/0", prod_w[0], busy_w[0], done_w[0]);
        end
        reset_n = 1'b1;
        repeat (15) begin
            @(posedge clock);
            if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) stray = 1;
        end
        checks++;
        if (stray) begin
            failures++;
            $display("FAIL reset_mid_stray: activity after reset, required idle");
        end
        run_op(0, 8'd9, 8'd9, 0, "after_reset_9x9");
    endtask

    initial begin
        for (int c = 0; c < 4; c++) begin
            start_r[c] = 1'b0;
            a_r[c] = '0;
            b_r[c] = '0;
        end
        test_reset();
        test_unsigned();
        test_signed();
        test_early_exit();
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
